bj_redirect_ctrl: RTL and testbench

- Sequences the control-flow redirect after the EX-stage branch/jump decision in the RV32IM 5-stage pipeline.
- Takes the detector's taken flag and computed target, then drives the PC-mux select and the pipeline flushes.
- Holds a redirect while instruction fetch is busy, and squashes wrong-path branch resolves.
- Keeps saturating branch and taken counters for performance monitoring.

---
 rtl/bj_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_bj_redirect_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bj_redirect_ctrl.sv
// rtl/bj_redirect_ctrl.sv - EX-stage branch/jump redirect sequencer with saturating perf counters
module bj_redirect_ctrl #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BJ_VALID,
  input  logic [2:0]           BRANCH_JUMP,
  input  logic                 PC_SEL_IN,
  input  logic [31:0]          TARGET_ADDR,
  input  logic                 EX_STALL,
  input  logic                 IMEM_BUSY,
  input  logic                 CNT_CLR,
  output logic                 PC_SEL,
  output logic [31:0]          PC_TARGET,
  output logic                 FLUSH_IF_ID,
  output logic                 FLUSH_ID_EX,
  output logic                 FLUSH_EX,
  output logic                 REDIRECT_PENDING,
  output logic [CNT_WIDTH-1:0] BRANCH_COUNT,
  output logic [CNT_WIDTH-1:0] TAKEN_COUNT
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_FETCH = 2'd1;
  localparam logic [1:0] REDIRECT   = 2'd2;

  localparam logic [2:0] BJ_NONE = 3'b010;
  localparam logic [2:0] BJ_JUMP = 3'b011;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [31:0]          pc_target_q, pc_target_d;
  logic                 pc_sel_q, pc_sel_d;
  logic                 flush_q, flush_d;
  logic                 pending_q, pending_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] taken_count_q, taken_count_d;
  logic                 accept;
  logic                 taken;

  // Resolve qualification: only one resolve is taken per redirect; anything seen
  // while a redirect is in flight is on the wrong path and is dropped.
  always_comb begin
    accept = BJ_VALID & ~EX_STALL & (BRANCH_JUMP != BJ_NONE) & (state_q == IDLE);
    taken  = accept & (PC_SEL_IN | (BRANCH_JUMP == BJ_JUMP));
  end

  // Redirect FSM and target latch; outputs are decoded from the next state so
  // they come straight off flops aligned with the state they describe.
  always_comb begin
    state_d     = state_q;
    pc_target_d = pc_target_q;
    case (state_q)
      IDLE: begin
        if (taken) begin
          pc_target_d = TARGET_ADDR;
          state_d     = IMEM_BUSY ? WAIT_FETCH : REDIRECT;
        end
      end
      WAIT_FETCH: begin
        if (!IMEM_BUSY) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    pc_sel_d  = (state_d == REDIRECT);
    flush_d   = (state_d != IDLE);
    pending_d = (state_d != IDLE);
  end

  // Saturating performance counters; a clear beats a same-cycle increment.
  always_comb begin
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (CNT_CLR) begin
      branch_count_d = '0;
      taken_count_d  = '0;
    end else begin
      if (accept && (branch_count_q != CNT_MAX)) begin
        branch_count_d = branch_count_q + CNT_ONE;
      end
      if (taken && (taken_count_q != CNT_MAX)) begin
        taken_count_d = taken_count_q + CNT_ONE;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      pc_target_q    <= '0;
      pc_sel_q       <= 1'b0;
      flush_q        <= 1'b0;
      pending_q      <= 1'b0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_target_q    <= pc_target_d;
      pc_sel_q       <= pc_sel_d;
      flush_q        <= flush_d;
      pending_q      <= pending_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  assign PC_SEL           = pc_sel_q;
  assign PC_TARGET        = pc_target_q;
  assign FLUSH_IF_ID      = flush_q;
  assign FLUSH_ID_EX      = flush_q;
  assign FLUSH_EX         = flush_q;
  assign REDIRECT_PENDING = pending_q;
  assign BRANCH_COUNT     = branch_count_q;
  assign TAKEN_COUNT      = taken_count_q;

endmodule

// File: tb/tb_bj_redirect_ctrl.sv
// tb/tb_bj_redirect_ctrl.sv - directed self-checking bench for bj_redirect_ctrl
module tb_bj_redirect_ctrl;

  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          BJ_VALID;
  logic [2:0]    BRANCH_JUMP;
  logic          PC_SEL_IN;
  logic [31:0]   TARGET_ADDR;
  logic          EX_STALL;
  logic          IMEM_BUSY;
  logic          CNT_CLR;
  logic          PC_SEL;
  logic [31:0]   PC_TARGET;
  logic          FLUSH_IF_ID;
  logic          FLUSH_ID_EX;
  logic          FLUSH_EX;
  logic          REDIRECT_PENDING;
  logic [CW-1:0] BRANCH_COUNT;
  logic [CW-1:0] TAKEN_COUNT;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_tgt;
  int exp_br = 0;
  int exp_tk = 0;

  bj_redirect_ctrl #(.CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RESET(RESET), .BJ_VALID(BJ_VALID), .BRANCH_JUMP(BRANCH_JUMP),
    .PC_SEL_IN(PC_SEL_IN), .TARGET_ADDR(TARGET_ADDR), .EX_STALL(EX_STALL),
    .IMEM_BUSY(IMEM_BUSY), .CNT_CLR(CNT_CLR), .PC_SEL(PC_SEL), .PC_TARGET(PC_TARGET),
    .FLUSH_IF_ID(FLUSH_IF_ID), .FLUSH_ID_EX(FLUSH_ID_EX), .FLUSH_EX(FLUSH_EX),
    .REDIRECT_PENDING(REDIRECT_PENDING), .BRANCH_COUNT(BRANCH_COUNT), .TAKEN_COUNT(TAKEN_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {PC_SEL, FLUSH_IF_ID, FLUSH_ID_EX, FLUSH_EX, REDIRECT_PENDING}
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, PC_SEL, FLUSH_IF_ID, FLUSH_ID_EX, FLUSH_EX, REDIRECT_PENDING}, {27'd0, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_br"}, {28'd0, BRANCH_COUNT}, exp_br);
    chk({tag, "_tk"}, {28'd0, TAKEN_COUNT}, exp_tk);
  endtask

  // Advance one clock, then pop the scoreboard whenever the DUT redirects.
  task automatic step();
    @(posedge CLK);
    #1;
    if (PC_SEL === 1'b1) begin
      total++;
      assert (sb_q.size() > 0) else begin
        bad++;
        $error("FAIL sb_unexpected_redirect observed=PC_SEL@%h expected=no_redirect", PC_TARGET);
      end
      if (sb_q.size() > 0) begin
        exp_tgt = sb_q.pop_front();
        chk("sb_target", PC_TARGET, exp_tgt);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] bj, input logic sel,
                       input logic [31:0] tgt, input logic stall, input logic busy);
    BJ_VALID    = v;
    BRANCH_JUMP = bj;
    PC_SEL_IN   = sel;
    TARGET_ADDR = tgt;
    EX_STALL    = stall;
    IMEM_BUSY   = busy;
  endtask

  function automatic int sat(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  initial begin
    RESET = 1'b1;
    CNT_CLR = 1'b0;
    drive(0, 3'b010, 0, 32'h0, 0, 0);
    step();
    step();
    RESET = 1'b0;
    chk_out("reset_out", 5'b00000);
    chk("reset_target", PC_TARGET, 32'h0);
    chk_cnt("reset_cnt");

    // Taken BEQ with fetch ready
    drive(1, 3'b000, 1, 32'h40, 0, 0);
    sb_q.push_back(32'h40);
    exp_br = sat(exp_br); exp_tk = sat(exp_tk);
    step();
    chk_out("beq_redirect", 5'b11111);
    chk_cnt("beq_cnt");
    drive(0, 3'b010, 0, 32'h0, 0, 0);
    step();
    chk_out("beq_after", 5'b00000);
    chk("beq_hold_target", PC_TARGET, 32'h40);

    // Not-taken BNE, then a "none" code
    drive(1, 3'b001, 0, 32'h80, 0, 0);
    exp_br = sat(exp_br);
    step();
    chk_out("bne_out", 5'b00000);
    chk_cnt("bne_cnt");
    drive(1, 3'b010, 1, 32'h84, 0, 0);
    step();
    chk_out("none_out", 5'b00000);
    chk_cnt("none_cnt");
    chk("none_target", PC_TARGET, 32'h40);

    // JAL while fetch busy; a wrong-path taken resolve during the wait is ignored
    drive(1, 3'b011, 0, 32'h100, 0, 1);
    sb_q.push_back(32'h100);
    exp_br = sat(exp_br); exp_tk = sat(exp_tk);
    step();
    chk_out("busy_wait1", 5'b01111);
    drive(1, 3'b000, 1, 32'h200, 0, 1);
    step();
    chk_out("busy_wait2", 5'b01111);
    step();
    chk_out("busy_wait3", 5'b01111);
    IMEM_BUSY = 1'b0;
    step();
    chk_out("busy_redirect", 5'b11111);
    chk("busy_target", PC_TARGET, 32'h100);
    drive(0, 3'b010, 0, 32'h0, 0, 0);
    step();
    chk_out("busy_after", 5'b00000);
    chk("busy_hold_target", PC_TARGET, 32'h100);
    chk_cnt("busy_cnt");

    // EX stall holds the resolve off; counted once when it drops
    drive(1, 3'b000, 1, 32'h300, 1, 0);
    step();
    chk_out("stall1", 5'b00000);
    step();
    chk_out("stall2", 5'b00000);
    chk_cnt("stall_cnt_hold");
    EX_STALL = 1'b0;
    sb_q.push_back(32'h300);
    exp_br = sat(exp_br); exp_tk = sat(exp_tk);
    step();
    chk_out("stall_redirect", 5'b11111);
    drive(0, 3'b010, 0, 32'h0, 0, 0);
    step();
    chk_out("stall_after", 5'b00000);
    chk_cnt("stall_cnt");

    // Reset in the middle of a busy-fetch wait abandons the redirect
    drive(1, 3'b011, 0, 32'h500, 0, 1);
    step();
    chk_out("rst_wait", 5'b01111);
    drive(0, 3'b010, 0, 32'h0, 0, 1);
    RESET = 1'b1;
    step();
    step();
    RESET = 1'b0;
    IMEM_BUSY = 1'b0;
    exp_br = 0; exp_tk = 0;
    chk_out("rst_mid_out", 5'b00000);
    chk("rst_mid_target", PC_TARGET, 32'h0);
    chk_cnt("rst_mid_cnt");
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("rst_no_pulse", 5'b00000);
    end

    // Saturation: 17 taken resolves on 4-bit counters
    for (int i = 0; i < 17; i++) begin
      drive(1, 3'b000, 1, 32'h1000 + 32'(i * 4), 0, 0);
      sb_q.push_back(32'h1000 + 32'(i * 4));
      exp_br = sat(exp_br); exp_tk = sat(exp_tk);
      step();
      drive(0, 3'b010, 0, 32'h0, 0, 0);
      step();
    end
    chk_cnt("sat_cnt");
    chk("sat_br_max", {28'd0, BRANCH_COUNT}, 32'd15);

    // Clear wins over a same-cycle taken accept
    drive(1, 3'b011, 1, 32'h2000, 0, 0);
    CNT_CLR = 1'b1;
    sb_q.push_back(32'h2000);
    exp_br = 0; exp_tk = 0;
    step();
    CNT_CLR = 1'b0;
    drive(0, 3'b010, 0, 32'h0, 0, 0);
    chk_out("clr_redirect", 5'b11111);
    chk_cnt("clr_cnt");
    step();
    chk_out("clr_after", 5'b00000);

    chk("sb_drained", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
